cdc_hs_arbiter: RTL and testbench



---
 rtl/cdc_hs_pkg.sv | 13 +
 rtl/ack_sync.sv | 24 ++
 rtl/cdc_hs_arbiter.sv | 170 +++++++++++++++++
 tb/tb_cdc_hs_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: shared types and constants for the CDC handshake arbiter.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } hs_state_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/ack_sync.sv
// ack_sync: multi-flop level synchronizer bringing the far-domain acknowledge into clk.
module ack_sync
  import cdc_hs_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

  // Shift chain; only the last stage is visible to the local domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_hs_arbiter.sv
// cdc_hs_arbiter: round-robin arbitration of NREQ requesters onto one four-phase req/ack crossing.
// Define CDC_HS_TIMEOUT_EN to add a per-phase handshake timeout reported on req_err.
module cdc_hs_arbiter
  import cdc_hs_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_done,
  output logic [NREQ-1:0]         req_err,
  output logic                    xreq,
  output logic [DW-1:0]           xdata,
  input  logic                    xack,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IW = $clog2(NREQ);

  hs_state_e         r_state;
  hs_state_e         w_next;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_grant;
  logic [IW-1:0]     w_win;
  logic              w_any;
  logic              w_grant;
  logic              w_ack_s;
  logic              w_tmo;
  logic              r_xreq;
  logic              r_busy;
  logic [DW-1:0]     r_xdata;
  logic [NREQ-1:0]   r_req_done;
  int                w_idx;

  ack_sync u_ack_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (xack),
    .o_sync  (w_ack_s)
  );

  // Scan downward so the valid requester nearest to r_ptr is the last one written.
  always_comb begin
    w_any = 1'b0;
    w_win = {IW{1'b0}};
    w_idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end else begin
        w_idx = w_idx;
      end
      if (req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = IW'(w_idx);
      end else begin
        w_any = w_any;
      end
    end
  end

  // A stale high ack blocks new grants so it can never complete a fresh transfer.
  assign w_grant = (r_state == IDLE) && w_any && !w_ack_s;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) w_next = REQ;
        else         w_next = IDLE;
      end
      REQ: begin
        if (w_ack_s || w_tmo) w_next = ACK;
        else                  w_next = REQ;
      end
      ACK: begin
        if (!w_ack_s || w_tmo) w_next = DONE;
        else                   w_next = ACK;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= {IW{1'b0}};
      r_grant    <= {IW{1'b0}};
      r_xreq     <= 1'b0;
      r_busy     <= 1'b0;
      r_xdata    <= {DW{1'b0}};
      r_req_done <= {NREQ{1'b0}};
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next != IDLE);
      r_req_done <= {NREQ{1'b0}};
      if (w_grant) begin
        r_xdata <= req_data[int'(w_win)*DW +: DW];
        r_grant <= w_win;
        r_ptr   <= (w_win == IW'(NREQ - 1)) ? {IW{1'b0}} : w_win + 1'b1;
        r_xreq  <= 1'b1;
      end else if ((r_state == REQ) && (w_next == ACK)) begin
        r_xreq  <= 1'b0;
      end
      if ((r_state == ACK) && (w_next == DONE)) begin
        r_req_done <= {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
      end
    end
  end

`ifdef CDC_HS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0]   r_cnt;
  logic            r_err_flag;
  logic [NREQ-1:0] r_req_err;

  // Counter restarts on every state change, so it measures time spent in the current phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {CW{1'b0}};
    end else if (w_next != r_state) begin
      r_cnt <= {CW{1'b0}};
    end else if ((r_state == REQ) || (r_state == ACK)) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= {CW{1'b0}};
    end
  end

  assign w_tmo = (r_cnt == CW'(TIMEOUT - 1)) &&
                 (((r_state == REQ) && !w_ack_s) || ((r_state == ACK) && w_ack_s));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_flag <= 1'b0;
      r_req_err  <= {NREQ{1'b0}};
    end else begin
      r_req_err <= {NREQ{1'b0}};
      if (w_grant) begin
        r_err_flag <= 1'b0;
      end else if (w_tmo) begin
        r_err_flag <= 1'b1;
      end
      if ((r_state == ACK) && (w_next == DONE) && (r_err_flag || w_tmo)) begin
        r_req_err <= {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
      end
    end
  end

  assign req_err = r_req_err;
`else
  assign w_tmo   = 1'b0;
  assign req_err = {NREQ{1'b0}};
`endif

  assign req_done = r_req_done;
  assign xreq     = r_xreq;
  assign xdata    = r_xdata;
  assign busy     = r_busy;
  assign grant_id = r_grant;

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// tb_cdc_hs_arbiter: directed bench with a grant/done scoreboard for cdc_hs_arbiter (NREQ=2).
module tb_cdc_hs_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 32;

  typedef struct packed {
    logic [0:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_done;
  logic [NREQ-1:0]   req_err;
  logic              xreq;
  logic [DW-1:0]     xdata;
  logic              xack;
  logic              busy;
  logic [0:0]        grant_id;

  logic r_loop = 1'b1;
  logic r_far  = 1'b0;
  logic exp_err = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t       exp_q[$];
  logic [0:0] done_q[$];
  int         rise_t[$];
  logic [DW-1:0] cur_data;

  assign xack = r_loop ? xreq : r_far;

  cdc_hs_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_done  (req_done),
    .req_err   (req_err),
    .xreq      (xreq),
    .xdata     (xdata),
    .xack      (xack),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [0:0] id, input logic [DW-1:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Requesters hold valid until they have seen the requested number of dones.
  task automatic run_xfers(input int r0, input int r1, input int budget);
    int  rem0;
    int  rem1;
    logic ok;
    rem0 = r0;
    rem1 = r1;
    ok   = 1'b0;
    req_valid = {1'(r1 > 0), 1'(r0 > 0)};
    for (int i = 0; i < budget; i++) begin
      step();
      if (req_done[0]) begin
        rem0--;
        if (rem0 == 0) req_valid[0] = 1'b0;
      end
      if (req_done[1]) begin
        rem1--;
        if (rem1 == 0) req_valid[1] = 1'b0;
      end
      if (rem0 <= 0 && rem1 <= 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("xfer_within_budget", 64'(ok), 64'd1);
    req_valid = 2'b00;
  endtask

  // Scoreboard monitor: checks each grant, data hold while xreq is high, and each done pulse.
  initial begin
    logic       prev;
    exp_t       e;
    logic [0:0] id;
    prev = 1'b0;
    forever begin
      step();
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (xreq && !prev) begin
          rise_t.push_back(cyc);
          chk("grant_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("grant_id", 64'(grant_id), 64'(e.id));
            chk("xdata_at_grant", 64'(xdata), 64'(e.data));
            cur_data = e.data;
            done_q.push_back(e.id);
          end
        end else if (xreq && prev) begin
          chk("xdata_hold", 64'(xdata), 64'(cur_data));
        end
        if (req_done != 2'b00) begin
          chk("done_expected", 64'(done_q.size() != 0), 64'd1);
          if (done_q.size() != 0) begin
            id = done_q.pop_front();
            chk("req_done", 64'(req_done), 64'(2'(2'b01 << id)));
            chk("req_err", 64'(req_err), exp_err ? 64'(req_done) : 64'd0);
          end
        end
        prev = xreq;
      end
    end
  end

  initial begin
    int t;
    int n_stuck;
    reset     = 1'b1;
    req_valid = 2'b00;
    req_data  = 64'd0;
    repeat (3) step();

    chk("rst_xreq", 64'(xreq), 64'd0);
    chk("rst_xdata", 64'(xdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_req_done", 64'(req_done), 64'd0);
    chk("rst_req_err", 64'(req_err), 64'd0);

    // Single loopback transfer with cycle-exact latency checks.
    reset = 1'b0;
    repeat (3) step();
    req_data[31:0] = 32'hDEADBEEF;
    push_exp(1'b0, 32'hDEADBEEF);
    req_valid = 2'b01;
    t = cyc;
    step();
    chk("t1_xreq_rise", 64'(xreq), 64'd1);
    chk("t1_xdata", 64'(xdata), 64'hDEADBEEF);
    chk("t1_busy", 64'(busy), 64'd1);
    repeat (5) step();
    chk("t1_no_early_done", 64'(req_done), 64'd0);
    step();
    chk("t1_done_t7", 64'(req_done), 64'd1);
    chk("t1_cycle", 64'(cyc - t), 64'd7);
    req_valid = 2'b00;
    step();
    chk("t1_idle_t8", 64'(busy), 64'd0);
    repeat (2) step();

    // Both valid out of reset: order 0 then 1, 8 cycles apart.
    reset = 1'b1;
    repeat (2) step();
    req_data = {32'h00000022, 32'h00000011};
    push_exp(1'b0, 32'h11);
    push_exp(1'b1, 32'h22);
    rise_t.delete();
    reset = 1'b0;
    run_xfers(1, 1, 60);
    chk("t2_rise_count", 64'(rise_t.size()), 64'd2);
    if (rise_t.size() == 2) chk("t2_rise_spacing", 64'(rise_t[1] - rise_t[0]), 64'd8);

    // Continuous contention alternates; a dropped requester leaves the other back-to-back.
    req_data = {32'hB1B1B1B1, 32'hA0A0A0A0};
    push_exp(1'b0, 32'hA0A0A0A0);
    push_exp(1'b1, 32'hB1B1B1B1);
    push_exp(1'b0, 32'hA0A0A0A0);
    push_exp(1'b1, 32'hB1B1B1B1);
    run_xfers(2, 2, 100);
    push_exp(1'b0, 32'hA0A0A0A0);
    push_exp(1'b1, 32'hB1B1B1B1);
    push_exp(1'b1, 32'hB1B1B1B1);
    run_xfers(1, 2, 100);
    chk("t3_queue_drained", 64'(exp_q.size() + done_q.size()), 64'd0);

    // Stale high ack blocks any grant.
    r_loop = 1'b0;
    r_far  = 1'b1;
    repeat (4) step();
    req_data[31:0] = 32'h5A5A5A5A;
    req_valid = 2'b01;
    repeat (10) step();
    chk("stale_ack_no_xreq", 64'(xreq), 64'd0);
    chk("stale_ack_not_busy", 64'(busy), 64'd0);
    push_exp(1'b0, 32'h5A5A5A5A);
    r_far  = 1'b0;
    r_loop = 1'b1;
    run_xfers(1, 0, 60);

`ifdef CDC_HS_TIMEOUT_EN
    // Ack never arrives: REQ times out, ACK exits, done and err pulse together.
    r_loop = 1'b0;
    r_far  = 1'b0;
    exp_err = 1'b1;
    req_data[31:0] = 32'h0BADC0DE;
    push_exp(1'b0, 32'h0BADC0DE);
    req_valid = 2'b01;
    t = cyc;
    step();
    chk("tmo_xreq_rise", 64'(xreq), 64'd1);
    repeat (15) step();
    chk("tmo_xreq_t16", 64'(xreq), 64'd1);
    step();
    chk("tmo_xreq_fall_t17", 64'(xreq), 64'd0);
    step();
    chk("tmo_done_t18", 64'(req_done), 64'd1);
    chk("tmo_err_t18", 64'(req_err), 64'd1);
    chk("tmo_cycle", 64'(cyc - t), 64'd18);
    req_valid = 2'b00;
    step();
    exp_err = 1'b0;
    chk("tmo_idle", 64'(busy), 64'd0);
    n_stuck = 5;
`else
    // Slow far side: xack rises 20 cycles after xreq and falls once xreq has dropped.
    r_loop = 1'b0;
    r_far  = 1'b0;
    req_data[31:0] = 32'h600DF00D;
    push_exp(1'b0, 32'h600DF00D);
    req_valid = 2'b01;
    t = cyc;
    step();
    chk("slow_xreq_rise", 64'(xreq), 64'd1);
    req_data[31:0] = 32'hBAD0BAD0;
    repeat (20) step();
    r_far = 1'b1;
    repeat (2) step();
    chk("slow_xreq_held_t23", 64'(xreq), 64'd1);
    chk("slow_xdata_held", 64'(xdata), 64'h600DF00D);
    step();
    chk("slow_xreq_fall_t24", 64'(xreq), 64'd0);
    r_far = 1'b0;
    repeat (2) step();
    chk("slow_no_early_done", 64'(req_done), 64'd0);
    step();
    chk("slow_done_3_after_ack_fall", 64'(req_done), 64'd1);
    chk("slow_cycle", 64'(cyc - t), 64'd27);
    req_valid = 2'b00;
    step();
    n_stuck = 1000;
`endif

    // Ack stuck low, then reset asserted while in REQ.
    r_loop = 1'b0;
    r_far  = 1'b0;
    req_data[31:0] = 32'h13572468;
    push_exp(1'b0, 32'h13572468);
    req_valid = 2'b01;
    step();
    repeat (n_stuck) step();
    chk("stuck_xreq_high", 64'(xreq), 64'd1);
    chk("stuck_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_xreq", 64'(xreq), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_no_done", 64'(req_done), 64'd0);
    done_q.delete();
    repeat (3) step();
    reset  = 1'b0;
    r_loop = 1'b1;
    req_data[31:0] = 32'h2468ACE0;
    push_exp(1'b0, 32'h2468ACE0);
    run_xfers(1, 0, 60);
    repeat (3) step();
    chk("final_queue_drained", 64'(exp_q.size() + done_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends with a summary.
  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
